// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard: register index width,
// default result latencies and the countdown counter width.
package hazard_pkg;

    localparam int REG_W        = 5;
    localparam int NREG         = 32;
    localparam int LAT_ALU      = 0;
    localparam int LOAD_LAT_DEF = 1;
    localparam int MUL_LAT_DEF  = 3;

    // Width needed to hold the longest latency (and zero).
    function automatic int hz_cnt_w(input int load_lat, input int mul_lat);
        int max_lat;
        max_lat = (load_lat > mul_lat) ? load_lat : mul_lat;
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

    localparam int CNT_W = hz_cnt_w(LOAD_LAT_DEF, MUL_LAT_DEF);

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle. The ID side (master) presents the
// decoded instruction; the scoreboard (slave) answers with stall/bubble/issue.
// Optional HZ_STALL_CNT_EN adds a free-running stall-cycle counter output.
interface hazard_scoreboard_if;
    import hazard_pkg::*;

    logic             id_valid_i;
    logic [REG_W-1:0] id_rs_i;
    logic [REG_W-1:0] id_rt_i;
    logic             id_use_rt_i;
    logic [REG_W-1:0] id_rd_i;
    logic             id_regwrite_i;
    logic             id_memread_i;
    logic             id_mul_i;
    logic             flush_i;
    logic             stall_o;
    logic             bubble_o;
    logic             issue_o;
`ifdef HZ_STALL_CNT_EN
    logic [31:0]      stall_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rt_i, id_rd_i,
               id_regwrite_i, id_memread_i, id_mul_i, flush_i,
        input  stall_o, bubble_o, issue_o, stall_cnt_o
    );
    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rt_i, id_rd_i,
               id_regwrite_i, id_memread_i, id_mul_i, flush_i,
        output stall_o, bubble_o, issue_o, stall_cnt_o
    );
`else
    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rt_i, id_rd_i,
               id_regwrite_i, id_memread_i, id_mul_i, flush_i,
        input  stall_o, bubble_o, issue_o
    );
    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rt_i, id_rd_i,
               id_regwrite_i, id_memread_i, id_mul_i, flush_i,
        output stall_o, bubble_o, issue_o
    );
`endif

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One countdown cell: loads a latency on issue, otherwise counts down to zero
// and holds. busy_o is high while the count is nonzero.
module hz_sb_entry #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         busy_o
);

    logic [W-1:0] cnt_r;

    // Load overrides the per-cycle decrement; zero is a resting state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r <= {W{1'b0}};
        end else if (load_i) begin
            cnt_r <= load_val_i;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o  = cnt_r;
    assign busy_o = (cnt_r != {W{1'b0}});

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard. Tracks per-register remaining result latency
// of in-flight writers plus multiplier occupancy, and raises stall/bubble for
// load-use, MUL RAW, MUL structural and WAW hazards. A flush always wins.
// Optional feature macro: HZ_STALL_CNT_EN (adds stall_cnt_o stall-cycle counter).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int MUL_LAT  = MUL_LAT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    hazard_scoreboard_if.slave  hz
);

    localparam int CW = hz_cnt_w(LOAD_LAT, MUL_LAT);

    logic [CW-1:0]   cnt_s [NREG];
    logic [NREG-1:0] busy_s;
    logic [NREG-1:1] load_s;
    logic [CW-1:0]   lat_s;
    logic [CW-1:0]   mul_cnt_s;
    logic            mul_busy_s;
    logic            mul_load_s;
    logic            raw_s;
    logic            waw_s;
    logic            struc_s;
    logic            stall_s;
    logic            issue_s;

    // Register 0 is hardwired: never busy, count reads zero.
    assign cnt_s[0]  = {CW{1'b0}};
    assign busy_s[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        hz_sb_entry #(.W(CW)) u_entry (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .load_i     (load_s[r]),
            .load_val_i (lat_s),
            .cnt_o      (cnt_s[r]),
            .busy_o     (busy_s[r])
        );
    end

    hz_sb_entry #(.W(CW)) u_mul_busy (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (mul_load_s),
        .load_val_i (CW'(MUL_LAT)),
        .cnt_o      (mul_cnt_s),
        .busy_o     (mul_busy_s)
    );

    // Result latency of the ID instruction; load wins if both load and mul are set.
    always_comb begin
        lat_s = CW'(LAT_ALU);
        if (hz.id_memread_i) begin
            lat_s = CW'(LOAD_LAT);
        end else if (hz.id_mul_i) begin
            lat_s = CW'(MUL_LAT);
        end else begin
            lat_s = CW'(LAT_ALU);
        end
    end

    // Hazard equations evaluated from the current scoreboard state.
    always_comb begin
        raw_s   = busy_s[hz.id_rs_i] | (hz.id_use_rt_i & busy_s[hz.id_rt_i]);
        waw_s   = hz.id_regwrite_i & (hz.id_rd_i != {REG_W{1'b0}}) &
                  (cnt_s[hz.id_rd_i] > lat_s);
        struc_s = hz.id_mul_i & mul_busy_s;
        stall_s = hz.id_valid_i & ~hz.flush_i & (raw_s | waw_s | struc_s);
        issue_s = hz.id_valid_i & ~hz.flush_i & ~stall_s;
    end

    // Issue decode: which destination entry (if any) and the multiplier get loaded.
    always_comb begin
        load_s     = '0;
        mul_load_s = issue_s & hz.id_mul_i;
        for (int r = 1; r < NREG; r++) begin
            load_s[r] = issue_s & hz.id_regwrite_i & (hz.id_rd_i == REG_W'(r));
        end
    end

    assign hz.stall_o  = stall_s;
    assign hz.bubble_o = stall_s | hz.flush_i;
    assign hz.issue_o  = issue_s;

`ifdef HZ_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Free-running count of stalled cycles, wraps naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign hz.stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a time-based reference model
// (absolute cycle at which each register's result becomes forwardable) is
// compared against the DUT every cycle, plus directed stall-count checks.
module tb_hazard_scoreboard;

    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hazard_scoreboard_if hz ();

    hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hz      (hz)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: avail[r] = cycle number from which r is free again.
    int cyc = 0;
    int avail [32];
    int mul_free = 0;
    int exp_scnt = 0;
    logic exp_stall, exp_bubble, exp_issue;
    logic m_raw, m_waw, m_struc;
    int   m_lat;

    function automatic int rem_of(input logic [4:0] r);
        if (r == 5'd0) return 0;
        if (avail[r] > cyc) return avail[r] - cyc;
        return 0;
    endfunction

    function automatic int lat_of(input logic mr, input logic mul);
        if (mr) return LOAD_LAT;
        if (mul) return MUL_LAT;
        return 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Model state update on each clock edge; reset clears everything at once.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) avail[r] <= 0;
            mul_free <= 0;
            exp_scnt <= 0;
        end else begin
            if (exp_issue && hz.id_regwrite_i && hz.id_rd_i != 5'd0)
                avail[hz.id_rd_i] <= cyc + 1 + lat_of(hz.id_memread_i, hz.id_mul_i);
            if (exp_issue && hz.id_mul_i)
                mul_free <= cyc + 1 + MUL_LAT;
            if (exp_stall) exp_scnt <= exp_scnt + 1;
        end
    end

    // Per-cycle compare, mid-cycle away from the active edge.
    always @(negedge clk) begin
        m_raw   = (rem_of(hz.id_rs_i) > 0) || (hz.id_use_rt_i && rem_of(hz.id_rt_i) > 0);
        m_lat   = lat_of(hz.id_memread_i, hz.id_mul_i);
        m_waw   = hz.id_regwrite_i && (hz.id_rd_i != 5'd0) && (rem_of(hz.id_rd_i) > m_lat);
        m_struc = hz.id_mul_i && (mul_free > cyc);
        exp_stall  = hz.id_valid_i && !hz.flush_i && (m_raw || m_waw || m_struc);
        exp_bubble = exp_stall || hz.flush_i;
        exp_issue  = hz.id_valid_i && !hz.flush_i && !exp_stall;
        check("model_stall",  int'(hz.stall_o),  int'(exp_stall));
        check("model_bubble", int'(hz.bubble_o), int'(exp_bubble));
        check("model_issue",  int'(hz.issue_o),  int'(exp_issue));
`ifdef HZ_STALL_CNT_EN
        check("model_stall_cnt", int'(hz.stall_cnt_o), exp_scnt);
`endif
    end

    task automatic idle();
        hz.id_valid_i    = 1'b0;
        hz.id_rs_i       = 5'd0;
        hz.id_rt_i       = 5'd0;
        hz.id_use_rt_i   = 1'b0;
        hz.id_rd_i       = 5'd0;
        hz.id_regwrite_i = 1'b0;
        hz.id_memread_i  = 1'b0;
        hz.id_mul_i      = 1'b0;
        hz.flush_i       = 1'b0;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mul);
        hz.id_valid_i    = 1'b1;
        hz.id_rs_i       = rs;
        hz.id_rt_i       = rt;
        hz.id_use_rt_i   = use_rt;
        hz.id_rd_i       = rd;
        hz.id_regwrite_i = rw;
        hz.id_memread_i  = mr;
        hz.id_mul_i      = mul;
        hz.flush_i       = 1'b0;
    endtask

    // Present an instruction until it issues; returns the number of stall cycles.
    task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mul,
                        output int stalls);
        bit done;
        done   = 1'b0;
        stalls = 0;
        drive(rs, rt, use_rt, rd, rw, mr, mul);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (hz.issue_o) done = 1'b1;
            else if (hz.stall_o) stalls++;
            @(posedge clk); #1;
        end
        if (!done) check("issue_timeout", 0, 1);
        idle();
    endtask

    task automatic gap(input int n);
        idle();
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int s;

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_stall",  int'(hz.stall_o),  0);
        check("reset_bubble", int'(hz.bubble_o), 0);
        check("reset_issue",  int'(hz.issue_o),  0);
        @(posedge clk); #1;

        // lw $2 then add $3,$2,$4: one load-use stall
        send(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, s);
        send(5'd2, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, s);
        check("load_use_stalls", s, 1);
        gap(4);

        // add $2 then sub $5,$2,$2: forwarded, no stall
        send(5'd1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, s);
        send(5'd2, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, s);
        check("alu_fwd_stalls", s, 0);
        gap(4);

        // mul $5 then add $6,$5,$0: three RAW stalls
        send(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, s);
        send(5'd5, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, s);
        check("mul_raw_stalls", s, 3);
        gap(4);

        // back-to-back independent muls: structural stall
        send(5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, s);
        send(5'd3, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, s);
        check("mul_struc_stalls", s, 3);
        gap(4);

        // mul $6 then lw $6: WAW stall, then a reader of $6 waits for the load
        send(5'd1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, s);
        send(5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, s);
        check("waw_stalls", s, 2);
        send(5'd6, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, s);
        check("after_waw_load_stalls", s, 1);
        gap(4);

        // lw $0 then add rs=$0: $0 is never tracked
        send(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, s);
        send(5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, s);
        check("r0_stalls", s, 0);
        gap(4);

        // flushed hazardous lw $9: flush wins, nothing recorded for $9
        send(5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, s);
        drive(5'd2, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
        hz.flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall",  int'(hz.stall_o),  0);
        check("flush_bubble", int'(hz.bubble_o), 1);
        check("flush_issue",  int'(hz.issue_o),  0);
        @(posedge clk); #1;
        send(5'd9, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, s);
        check("after_flush_stalls", s, 0);
        gap(4);

        // reset in the middle of a mul countdown
        send(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, s);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(5'd5, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("in_reset_stall", int'(hz.stall_o), 0);
        check("in_reset_issue", int'(hz.issue_o), 1);
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(5'd5, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, s);
        check("after_reset_stalls", s, 0);
        gap(2);

`ifdef HZ_STALL_CNT_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("stall_cnt_reset", int'(hz.stall_cnt_o), 0);
        send(5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, s);
        send(5'd5, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, s);
        check("stall_cnt_mul", int'(hz.stall_cnt_o), 3);
        gap(2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
